// File: rtl/t_7458_sweep.sv
// Exhaustive sweep-and-check sequencer for the t_7458 dual AND-OR gate.
// Define T7458_SWEEP_STOP_ON_ERR_EN to end the sweep at the first mismatch.
module t_7458_sweep #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [9:0]  vec,
    input  logic        p1y,
    input  logic        p2y,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [10:0] err_cnt,
    output logic [9:0]  first_err_vec,
    output logic        first_err_valid
);

    typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

    localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [9:0]  vec_q, vec_d;
    logic [7:0]  settle_q, settle_d;
    logic [10:0] err_q, err_d;
    logic [9:0]  first_vec_q, first_vec_d;
    logic        first_valid_q, first_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;

    logic exp1, exp2, mismatch, last_vec, stop_now;

    assign exp1     = (vec_q[0] & vec_q[1] & vec_q[2]) | (vec_q[3] & vec_q[4] & vec_q[5]);
    assign exp2     = (vec_q[6] & vec_q[7]) | (vec_q[8] & vec_q[9]);
    assign mismatch = (p1y != exp1) || (p2y != exp2);
    assign last_vec = (vec_q == 10'h3FF);

`ifdef T7458_SWEEP_STOP_ON_ERR_EN
    assign stop_now = mismatch | last_vec;
`else
    assign stop_now = last_vec;
`endif

    always_comb begin
        state_d       = state_q;
        vec_d         = vec_q;
        settle_d      = settle_q;
        err_d         = err_q;
        first_vec_d   = first_vec_q;
        first_valid_d = first_valid_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    vec_d         = '0;
                    settle_d      = '0;
                    err_d         = '0;
                    first_vec_d   = '0;
                    first_valid_d = 1'b0;
                    state_d       = StSettle;
                end
            end
            StSettle: begin
                settle_d = settle_q + 8'd1;
                if (settle_q == SettleLast) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    err_d = err_q + 11'd1;
                    if (!first_valid_q) begin
                        first_vec_d   = vec_q;
                        first_valid_d = 1'b1;
                    end
                end
                // On stop, vec holds the last checked (or failing) vector.
                if (stop_now) begin
                    state_d = StDone;
                end else begin
                    vec_d    = vec_q + 10'd1;
                    settle_d = '0;
                    state_d  = StSettle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Status flags are derived from next state so they stay registered.
        busy_d = (state_d == StSettle) || (state_d == StCheck);
        done_d = (state_d == StDone);
        pass_d = done_d && (err_d == 11'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            vec_q         <= '0;
            settle_q      <= '0;
            err_q         <= '0;
            first_vec_q   <= '0;
            first_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            vec_q         <= vec_d;
            settle_q      <= settle_d;
            err_q         <= err_d;
            first_vec_q   <= first_vec_d;
            first_valid_q <= first_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
        end
    end

    assign vec             = vec_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_q;
    assign first_err_vec   = first_vec_q;
    assign first_err_valid = first_valid_q;

endmodule

// File: tb/tb_t_7458_sweep.sv
// Bench for t_7458_sweep: a behavioural t_7458 with selectable faults closes the loop;
// each sweep's expected result is queued at start and checked when done rises.
module tb_t_7458_sweep;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  vec;
    logic        p1y, p2y;
    logic        busy, done, pass;
    logic [10:0] err_cnt;
    logic [9:0]  first_err_vec;
    logic        first_err_valid;

    int mode = 0; // 0 good, 1 p2y stuck 0, 2 p1y stuck 1, 3 p1y inverted at 10'h2A5
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    t_7458_sweep #(.SETTLE_CYCLES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .vec             (vec),
        .p1y             (p1y),
        .p2y             (p2y),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_cnt         (err_cnt),
        .first_err_vec   (first_err_vec),
        .first_err_valid (first_err_valid)
    );

    logic g1, g2;
    assign g1  = (vec[0] & vec[1] & vec[2]) | (vec[3] & vec[4] & vec[5]);
    assign g2  = (vec[6] & vec[7]) | (vec[8] & vec[9]);
    assign p1y = (mode == 2) ? 1'b1 : ((mode == 3) && (vec == 10'h2A5)) ? ~g1 : g1;
    assign p2y = (mode == 1) ? 1'b0 : g2;

    typedef struct {
        int mode;
        int err;
        int first;
        bit valid;
    } vec_t;

    typedef struct {
        int err;
        int first;
        bit valid;
        bit pass;
        int vec;
        int cycles;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[4];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic exp_t predict(input vec_t v);
        exp_t e;
        e.first = v.first;
        e.valid = v.valid;
`ifdef T7458_SWEEP_STOP_ON_ERR_EN
        if (v.valid) begin
            e.err    = 1;
            e.vec    = v.first;
            e.cycles = (v.first + 1) * 3;
        end else begin
            e.err    = 0;
            e.vec    = 'h3FF;
            e.cycles = 3072;
        end
`else
        e.err    = v.err;
        e.vec    = 'h3FF;
        e.cycles = 3072;
`endif
        e.pass = (e.err == 0);
        return e;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // restart_at >= 0 re-pulses start that many cycles into the sweep.
    task automatic run_sweep(input vec_t v, input int restart_at);
        exp_t e;
        int   cyc;
        mode = v.mode;
        sbq.push_back(predict(v));
        pulse_start();
        chk("busy_after_start", busy, 1);
        chk("vec_after_start", vec, 0);
        chk("err_cleared_on_start", err_cnt, 0);
        chk("valid_cleared_on_start", first_err_valid, 0);
        chk("done_cleared_on_start", done, 0);
        cyc = 0;
        while (!done && cyc < 4000) begin
            if (cyc == restart_at) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            cyc++;
        end
        e = sbq.pop_front();
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL sweep_timeout: done not seen after %0d cycles, expected at %0d",
                     cyc, e.cycles);
        end else begin
            chk("done_latency", cyc, e.cycles);
            chk("busy_at_done", busy, 0);
            chk("err_cnt", err_cnt, e.err);
            chk("first_err_vec", first_err_vec, e.first);
            chk("first_err_valid", first_err_valid, e.valid);
            chk("pass", pass, e.pass);
            chk("vec_at_done", vec, e.vec);
        end
    endtask

    initial begin
        tbl[0] = '{mode: 0, err: 0,   first: 'h000, valid: 1'b0};
        tbl[1] = '{mode: 1, err: 448, first: 'h0C0, valid: 1'b1};
        tbl[2] = '{mode: 2, err: 784, first: 'h000, valid: 1'b1};
        tbl[3] = '{mode: 3, err: 1,   first: 'h2A5, valid: 1'b1};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_vec", vec, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_first_valid", first_err_valid, 0);
        chk("rst_first_vec", first_err_vec, 0);

        // Each sweep starts from DONE of the previous one, exercising restart clearing.
        for (int i = 0; i < 4; i++) run_sweep(tbl[i], -1);
        run_sweep(tbl[1], -1);

        // Start during a sweep must be ignored.
        run_sweep(tbl[0], 100);

        // Reset mid-sweep.
        mode = 2;
        pulse_start();
        repeat (500) @(posedge clk);
        #1;
        chk("err_before_rst", (err_cnt > 0) ? 1 : 0, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_vec", vec, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        chk("midrst_first_valid", first_err_valid, 0);
        repeat (50) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_vec", vec, 0);
        chk("idle_done", done, 0);

        // rst beats start in the same cycle.
        @(negedge clk);
        start = 1'b1;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        chk("rst_wins_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("rst_wins_vec", vec, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
